// File: rtl/acc_ctrl_unit.sv
// acc_ctrl_unit: two-cycle FETCH/EXEC sequencer that owns the accumulator,
// program counter and zero flag, and drives the ALU and register file.
module acc_ctrl_unit #(
  parameter int PC_W  = 8,
  parameter int RF_AW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [8:0]       instr_in,
  output logic [PC_W-1:0]  pc_out,
  output logic [RF_AW-1:0] rf_addr,
  input  logic [7:0]       rf_rdata,
  output logic             rf_we,
  output logic [7:0]       rf_wdata,
  output logic [8:0]       alu_op,
  output logic [7:0]       alu_acc,
  input  logic [7:0]       alu_rslt,
  input  logic             alu_zero,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [2:0] OP_SUB = 3'd1;

  state_t          state, state_nxt;
  logic [8:0]      ir;
  logic [7:0]      acc;
  logic            zflag;
  logic [PC_W-1:0] pc;

  // Instruction class decode, all from the latched IR
  logic is_alu, is_lda, is_sta, is_bz, is_halt, is_ldi;
  assign is_alu  = ~ir[8];
  assign is_lda  = ir[8] && (ir[7:6] == 2'b00);
  assign is_sta  = ir[8] && (ir[7:6] == 2'b01);
  assign is_bz   = ir[8] && (ir[7:6] == 2'b10);
  assign is_halt = ir[8] && (ir[7:6] == 2'b11) &&  ir[5];
  assign is_ldi  = ir[8] && (ir[7:6] == 2'b11) && !ir[5];

  // Branch offset is a signed 6-bit field; wrap falls out of PC_W-bit add
  logic [PC_W-1:0] br_off;
  assign br_off = {{(PC_W-6){ir[5]}}, ir[5:0]};

  assign pc_out   = pc;
  assign rf_wdata = acc;
  assign alu_acc  = acc;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; HALT is terminal until reset
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC:  state_nxt = is_halt ? S_HALT : S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: only EXEC drives the ALU/RF, straight from IR so they are
  // stable for the whole cycle; reset drops rf_we immediately
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = '0;
    alu_op  = '0;
    done    = 1'b0;
    case (state)
      S_EXEC: begin
        if (is_alu) begin
          alu_op  = {6'b0, ir[7:5]};
          rf_addr = RF_AW'(ir[4:1]);
        end else if (is_lda) begin
          rf_addr = RF_AW'(ir[3:0]);
        end else if (is_sta) begin
          rf_addr = RF_AW'(ir[3:0]);
          rf_we   = 1'b1;
        end
      end
      S_HALT:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch IR in FETCH, commit results and advance pc in EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir    <= '0;
      acc   <= '0;
      zflag <= 1'b0;
      pc    <= '0;
    end else begin
      case (state)
        S_FETCH: ir <= instr_in;
        S_EXEC: begin
          if (is_alu) begin
            // SUB only sets the flag; everything else writes back
            if (ir[7:5] == OP_SUB) zflag <= alu_zero;
            else                   acc   <= alu_rslt;
          end else if (is_lda) begin
            acc <= rf_rdata;
          end else if (is_ldi) begin
            acc <= {3'b000, ir[4:0]};
          end
          // zflag is sticky across branches; offset 0 spins in place
          if (is_bz && zflag) pc <= pc + br_off;
          else if (!is_halt)  pc <= pc + PC_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_ctrl_unit.sv
// tb_acc_ctrl_unit: bench acts as ROM, register file and ALU around the DUT;
// table of short programs with expected final acc/pc, plus timed sequences.
module tb_acc_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] instr_in;
  logic [7:0] pc_out;
  logic [3:0] rf_addr;
  logic [7:0] rf_rdata;
  logic       rf_we;
  logic [7:0] rf_wdata;
  logic [8:0] alu_op;
  logic [7:0] alu_acc;
  logic [7:0] alu_rslt;
  logic       alu_zero;
  logic       done;

  int errors = 0;
  int checks = 0;

  logic [8:0] prog [256];
  logic [7:0] rf   [16];

  acc_ctrl_unit #(.PC_W(8), .RF_AW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .instr_in(instr_in),
    .pc_out(pc_out), .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_wdata(rf_wdata), .alu_op(alu_op), .alu_acc(alu_acc),
    .alu_rslt(alu_rslt), .alu_zero(alu_zero), .done(done)
  );

  always #5 clk = ~clk;

  // Reference ALU: acc operand op register operand
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a << b;
      3'd3: return a >> b;
      3'd4: return (a == b) ? 8'd1 : 8'd0;
      3'd5: return (a > b) ? 8'd1 : 8'd0;
      3'd6: return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign instr_in = prog[pc_out];
  assign rf_rdata = rf[rf_addr];
  assign alu_rslt = alu_f(alu_op[2:0], alu_acc, rf_rdata);
  assign alu_zero = (alu_rslt == 8'd0);

  // Register file writes at the end of the write cycle
  always @(posedge clk) if (rf_we) rf[rf_addr] <= rf_wdata;

  localparam logic [2:0] ADD = 0, SUB = 1, SLL = 2, SRL = 3, EQU = 4, GTR = 5, AND_ = 6, XOR_ = 7;
  localparam logic [8:0] H = 9'h1E0;

  function automatic logic [8:0] ldi(input int v); logic [4:0] i = v[4:0]; return {4'b1110, i}; endfunction
  function automatic logic [8:0] sta(input int r); logic [3:0] i = r[3:0]; return {5'b10100, i}; endfunction
  function automatic logic [8:0] lda(input int r); logic [3:0] i = r[3:0]; return {5'b10000, i}; endfunction
  function automatic logic [8:0] bz (input int o); logic [5:0] i = o[5:0]; return {3'b110, i}; endfunction
  function automatic logic [8:0] alu(input logic [2:0] op, input int r);
    logic [3:0] i = r[3:0];
    return {1'b0, op, i, 1'b0};
  endfunction

  typedef struct {
    string      name;
    logic [8:0] p [12];
    logic [7:0] acc;
    logic [7:0] pc;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(); @(posedge clk); #1; endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic pulse_start(); start = 1'b1; step(); start = 1'b0; endtask

  task automatic clear_prog(); for (int i = 0; i < 256; i++) prog[i] = H; endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while (!done && n < max) begin step(); n++; end
    chk({name, "_done"}, {31'b0, done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    vecs[0]  = '{"ldi_halt",   '{ldi(5), ldi(3), H, H, H, H, H, H, H, H, H, H}, 8'd3, 8'd2};
    vecs[1]  = '{"add_bit0",   '{ldi(10), sta(2), ldi(4), alu(ADD,2) | 9'd1, H, H, H, H, H, H, H, H}, 8'h0E, 8'd4};
    vecs[2]  = '{"sll",        '{ldi(2), sta(1), ldi(10), sta(2), ldi(4), alu(ADD,2), alu(SLL,1), H, H, H, H, H}, 8'h38, 8'd7};
    vecs[3]  = '{"bz_not",     '{ldi(6), sta(3), ldi(7), alu(SUB,3), bz(2), ldi(1), H, H, H, H, H, H}, 8'd1, 8'd6};
    vecs[4]  = '{"bz_taken",   '{ldi(7), sta(3), alu(SUB,3), bz(2), ldi(1), H, H, H, H, H, H, H}, 8'd7, 8'd5};
    vecs[5]  = '{"equ",        '{ldi(9), sta(5), alu(EQU,5), H, H, H, H, H, H, H, H, H}, 8'd1, 8'd3};
    vecs[6]  = '{"gtr",        '{ldi(9), sta(5), ldi(3), alu(GTR,5), H, H, H, H, H, H, H, H}, 8'd0, 8'd4};
    vecs[7]  = '{"and_xor",    '{ldi(28), sta(6), ldi(15), alu(AND_,6), alu(XOR_,6), H, H, H, H, H, H, H}, 8'h10, 8'd5};
    vecs[8]  = '{"srl",        '{ldi(2), sta(1), ldi(31), alu(SRL,1), H, H, H, H, H, H, H, H}, 8'd7, 8'd4};
    vecs[9]  = '{"sta_lda",    '{ldi(9), sta(4), ldi(0), lda(4), H, H, H, H, H, H, H, H}, 8'd9, 8'd4};
    vecs[10] = '{"z_sticky",   '{ldi(7), sta(3), alu(SUB,3), ldi(2), bz(2), ldi(5), H, H, H, H, H, H}, 8'd2, 8'd6};
    vecs[11] = '{"sub_keep",   '{ldi(3), sta(7), ldi(20), alu(SUB,7), alu(ADD,7), H, H, H, H, H, H, H}, 8'd23, 8'd5};
    vecs[12] = '{"z_reset",    '{bz(3), ldi(1), H, H, H, H, H, H, H, H, H, H}, 8'd1, 8'd2};
    clear_prog();
    for (int i = 0; i < 16; i++) rf[i] = 8'd0;

    // Reset state
    do_reset();
    chk("rst_pc", pc_out, 0);
    chk("rst_acc", alu_acc, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_addr", rf_addr, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_done", done, 0);

    // Table of programs: final acc and pc at HALT
    for (int v = 0; v < 13; v++) begin
      do_reset();
      clear_prog();
      for (int i = 0; i < 12; i++) prog[i] = vecs[v].p[i];
      pulse_start();
      wait_done(vecs[v].name, 60);
      chk({vecs[v].name, "_acc"}, alu_acc, vecs[v].acc);
      chk({vecs[v].name, "_pc"}, pc_out, vecs[v].pc);
    end

    // Cycle timing: LDI 5; LDI 3; HALT
    do_reset(); clear_prog();
    prog[0] = ldi(5); prog[1] = ldi(3);
    pulse_start();
    step(); step(); step(); step();
    chk("t1_acc_e4", alu_acc, 3);
    step();
    chk("t1_done_e5", done, 0);
    step();
    chk("t1_done_e6", done, 1);
    chk("t1_pc_e6", pc_out, 2);
    pulse_start(); step(); step();
    chk("t1_halt_done", done, 1);
    chk("t1_halt_pc", pc_out, 2);
    chk("t1_halt_we", rf_we, 0);

    // Operands during EXEC of ADD r2
    do_reset(); clear_prog();
    for (int i = 0; i < 12; i++) prog[i] = vecs[1].p[i];
    pulse_start();
    for (int i = 0; i < 7; i++) step();
    chk("t2_op", alu_op, 0);
    chk("t2_addr", rf_addr, 2);
    chk("t2_acc_in", alu_acc, 4);
    step();
    chk("t2_acc_out", alu_acc, 8'h0E);

    // Branch back past 0 then pc 255 + 1 wraps to 0
    do_reset(); clear_prog();
    prog[0] = ldi(7); prog[1] = sta(3); prog[2] = alu(SUB,3); prog[3] = bz(-4);
    prog[255] = ldi(3);
    pulse_start();
    for (int i = 0; i < 8; i++) step();
    chk("t3_pc_ff", pc_out, 8'hFF);
    step(); step();
    chk("t3_pc_wrap", pc_out, 0);
    chk("t3_acc", alu_acc, 3);

    // BZ offset 0 taken spins in place
    do_reset(); clear_prog();
    prog[0] = ldi(7); prog[1] = sta(3); prog[2] = alu(SUB,3); prog[3] = bz(0);
    pulse_start();
    for (int i = 0; i < 12; i++) step();
    chk("t4_spin_pc", pc_out, 3);
    chk("t4_spin_done", done, 0);

    // STA pulses rf_we for exactly one cycle
    begin
      int cnt = 0, n = 0;
      logic [3:0] wa = '0;
      logic [7:0] wd = '0;
      do_reset(); clear_prog();
      for (int i = 0; i < 12; i++) prog[i] = vecs[9].p[i];
      pulse_start();
      while (!done && n < 40) begin
        if (rf_we) begin cnt++; wa = rf_addr; wd = rf_wdata; end
        step(); n++;
      end
      chk("t5_we_cycles", cnt, 1);
      chk("t5_we_addr", wa, 4);
      chk("t5_we_data", wd, 9);
    end

    // Reset during EXEC of STA aborts the write
    do_reset(); clear_prog();
    prog[0] = ldi(3); prog[1] = sta(4);
    pulse_start();
    wait_done("t6_pre", 20);
    do_reset(); clear_prog();
    prog[0] = ldi(9); prog[1] = sta(4);
    pulse_start();
    step(); step(); step();
    chk("t6_we_before", rf_we, 1);
    reset = 1'b1; #1;
    chk("t6_we_drop", rf_we, 0);
    chk("t6_pc", pc_out, 0);
    chk("t6_acc", alu_acc, 0);
    chk("t6_done", done, 0);
    step();
    reset = 1'b0;
    chk("t6_rf_kept", rf[4], 3);
    step(); step(); step();
    chk("t6_idle_pc", pc_out, 0);
    chk("t6_idle_addr", rf_addr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
